alu_mul_seq: RTL
================

# alu_mul_seq

Iterative 64×64→64 (low half) unsigned multiply sequencer built on the processor's shared 64-bit ALU. It is the ALU's controller during a multiply: it drives the ALU operands and 4-bit control code one shift-add step per cycle, and feeds each ALU result back into its accumulator. It asserts `alu_req` to take the ALU away from the single-cycle datapath; the top-level operand mux uses `alu_req` as its select.

## Interface
- `XLEN`, 64: operand, product and ALU width. Fixed at 64; the parameter exists only for readability.
- `clk`  in  1: sole clock; rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a multiply; sampled only in IDLE or DONE.
- `op_a`  in  64: multiplicand; sampled with an accepted `start`.
- `op_b`  in  64: multiplier; sampled with an accepted `start`.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse when `product` becomes valid.
- `product`  out  64: low 64 bits of `op_a`×`op_b`; held until the next accepted `start`.
- `zero`  out  1: `product == 0`; registered together with `product`.
- `alu_req`  out  1: equals `busy`; selects this block's drive onto the ALU.
- `alu_a`  out  64: ALU operand a.
- `alu_b`  out  64: ALU operand b.
- `alu_ctrl`  out  4: ALU control code.
- `alu_result`  in  64: combinational ALU result for the current `alu_a`/`alu_b`/`alu_ctrl`.

## Operation
- **States:** IDLE, RUN, DONE.
- **Internal registers:**
  - `m`: 64-bit multiplicand, shifted left each step.
  - `q`: 64-bit multiplier, shifted right each step.
  - `acc`: 64-bit accumulator.
  - `cnt`: 6-bit step counter.
- **Accept:** in IDLE or DONE with `start`=1: `m`←`op_a`, `q`←`op_b`, `acc`←0, `cnt`←0, state→RUN. `product` and `zero` are unchanged at this point.
- **RUN step**, one per cycle:
  - If `q[0]`=1: `alu_ctrl`=ADD (0010), `alu_a`=`acc`, `alu_b`=`m`.
  - If `q[0]`=0: `alu_ctrl`=PASSB (0111), `alu_a`=0, `alu_b`=`acc`.
  - Each edge: `acc`←`alu_result`, `m`←`m`<<1 (bit 63 discarded), `q`←`q`>>1, `cnt`←`cnt`+1.
- **Termination:** exit RUN after the step in which (`q`>>1)==0 or `cnt`==63. On exit: `product`←`alu_result`, `zero`←(`alu_result`==0), state→DONE.
- **DONE:** `done`=1 for exactly this one cycle. The next state is IDLE, unless `start`=1, in which case a new operation is accepted and the next state is RUN.
- **Arithmetic:** all additions are modulo 2^64; there is no overflow or carry output.
- **Outside RUN:** `alu_ctrl`=0111, `alu_a`=0, `alu_b`=0, `alu_req`=0.
- **`start` during RUN:** ignored; the operands are not resampled.
- **Reset (any time, including mid-RUN):** state=IDLE, `product`=0, `zero`=1, `done`=0, `busy`=0, `alu_req`=0, all internal registers cleared. An in-flight multiply is dropped with no `done`.

## Timing
- `start` sampled at edge E0 → RUN during cycles E0..E0+n−1.
- n = 1 + index of the highest set bit of `op_b`; n=1 when `op_b`=0; maximum n=64.
- `done` and the new `product` are visible in the cycle after edge E0+n. Start-to-`done` latency is n+1 cycles.
- `busy` and `alu_req` rise in the cycle after the accepting edge and fall in the DONE cycle.
- Back-to-back: `start` held high in the DONE cycle yields the next RUN immediately, with no IDLE bubble.
- All outputs are registered, except `alu_a`, `alu_b` and `alu_ctrl`. Those are combinational from state, `q[0]`, `acc` and `m` only; they never depend on `alu_result`, so there is no combinational loop.

## Structure
- **Shared package `alu_pkg`:**
  - ALU control constants: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_PASSB=0111, ALU_NOR=1100.
  - `mulseq_state_t` enum {IDLE, RUN, DONE}.
- **Sub-modules:** none. The ALU stays external and shared; no separate ALU copy is instantiated.

## Test plan
- `op_a`=3, `op_b`=5, pulse `start` → 3 RUN cycles, `alu_ctrl` sequence 0010, 0111, 0010; `done` 4 cycles after the accepting edge; `product`=15, `zero`=0.
- `op_b`=0, `op_a`=0xDEAD → 1 RUN cycle with `alu_ctrl`=0111; `product`=0, `zero`=1; `done` 2 cycles after acceptance.
- `op_a`=`op_b`=0xFFFF_FFFF_FFFF_FFFF → 64 RUN cycles; `product`=1; `done` at 65 cycles.
- `start` re-pulsed mid-RUN with different operands → ignored; the original product is delivered; `start` held high in the DONE cycle → second operation begins the next cycle; `product` updates to 7×9=63.
- `reset_n` low during cycle 10 of a 64-step multiply → immediately state=IDLE, `busy`=0, `alu_req`=0, `product`=0, `zero`=1; no `done` pulse follows.
- Throughout all tests: `alu_req`==`busy`; outside RUN, `alu_ctrl`=0111 and `alu_a`=`alu_b`=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared between the processor's ALU and any block
// that borrows it.
//   - 4-bit ALU control codes.
//   - State encoding for the iterative multiply sequencer.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mulseq_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative 64x64 -> 64 (low half) unsigned multiplier that
// runs its shift-add steps on the shared external ALU, one step per cycle.
//
// Ports
//   clk, reset_n         clock (rising edge), async active-low reset
//   start, op_a, op_b    request; operands sampled when accepted in IDLE/DONE
//   busy                 high while stepping (RUN)
//   done                 one-cycle pulse when product becomes valid
//   product, zero        registered low 64-bit product and its zero flag
//   alu_req              takes the shared ALU (operand mux select), == busy
//   alu_a, alu_b,        ALU drive; combinational from state, q[0], acc, m
//   alu_ctrl
//   alu_result           combinational ALU result fed back into acc
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product,
  output logic            zero,
  output logic            alu_req,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  mulseq_state_t    state_r, state_d;
  logic [XLEN-1:0]  m_r;
  logic [XLEN-1:0]  q_r;
  logic [XLEN-1:0]  acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0]  product_r;
  logic             zero_r;

  logic accept;
  logic last_step;

  // A new request is only taken when not stepping.
  assign accept = start && (state_r != RUN);

  // Stop once no multiplier bits remain above the one consumed this cycle;
  // the counter bound is a backstop for op_b with bit 63 set.
  assign last_step = (q_r[XLEN-1:1] == '0) || (cnt_r == CNT_LAST);

  assign busy    = (state_r == RUN);
  assign alu_req = busy;
  assign done    = (state_r == DONE);
  assign product = product_r;
  assign zero    = zero_r;

  // ALU drive: add m into acc when the current multiplier bit is set,
  // otherwise pass acc through unchanged so the feedback path is uniform.
  always_comb begin
    alu_ctrl = ALU_PASSB;
    alu_a    = '0;
    alu_b    = '0;
    if (state_r == RUN) begin
      if (q_r[0]) begin
        alu_ctrl = ALU_ADD;
        alu_a    = acc_r;
        alu_b    = m_r;
      end else begin
        alu_ctrl = ALU_PASSB;
        alu_a    = '0;
        alu_b    = acc_r;
      end
    end
  end

  always_comb begin
    state_d = state_r;
    case (state_r)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_d;
    end
  end

  // Datapath; product/zero only change on the final step, so the previous
  // result stays visible through a later accept and the following RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_r       <= '0;
      q_r       <= '0;
      acc_r     <= '0;
      cnt_r     <= '0;
      product_r <= '0;
      zero_r    <= 1'b1;
    end else if (accept) begin
      m_r   <= op_a;
      q_r   <= op_b;
      acc_r <= '0;
      cnt_r <= '0;
    end else if (state_r == RUN) begin
      acc_r <= alu_result;
      m_r   <= m_r << 1;
      q_r   <= q_r >> 1;
      cnt_r <= cnt_r + CNT_W'(1);
      if (last_step) begin
        product_r <= alu_result;
        zero_r    <= (alu_result == '0);
      end
    end
  end

endmodule
